// File: rtl/lcd_pattern_sched.sv
// rtl/lcd_pattern_sched.sv - frame-aligned test pattern mode scheduler with debounced key and auto-cycle
module lcd_pattern_sched #(
   parameter int NUM_MODES    = 4,
   parameter int DEBOUNCE_CYC = 500000,
   parameter int DEBOUNCE_W   = 20,
   parameter int AUTO_FRAMES  = 120,
   parameter int AUTO_W       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_start,
   input  logic       key_n,
   input  logic       auto_en,
   output logic [1:0] mode_sel,
   output logic       mode_chg,
   output logic       req_pend
);

   localparam logic [DEBOUNCE_W-1:0] DB_LAST   = DEBOUNCE_W'(DEBOUNCE_CYC - 1);
   localparam logic [AUTO_W-1:0]     AUTO_LAST = AUTO_W'(AUTO_FRAMES - 1);
   localparam logic [1:0]            MODE_LAST = 2'(NUM_MODES - 1);

   typedef enum logic [1:0] {UP, DN_CHK, DOWN, UP_CHK} db_state_t;

   db_state_t             state, state_nxt;
   logic [DEBOUNCE_W-1:0] cnt, cnt_nxt;
   logic                  key_meta, key_s, key_evt;
   logic [AUTO_W-1:0]     auto_cnt;
   logic                  auto_hit, adv;

   // Two-flop synchronizer; idles released (1) so reset never looks like a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_meta <= 1'b1;
         key_s    <= 1'b1;
      end else begin
         key_meta <= key_n;
         key_s    <= key_meta;
      end
   end

   // Debounce state and stability counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= UP;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Debounce next-state: a level must hold DEBOUNCE_CYC cycles; only the press edge emits key_evt.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      key_evt   = 1'b0;
      case (state)
         UP: begin
            if (!key_s) begin
               state_nxt = DN_CHK;
               cnt_nxt   = '0;
            end
         end
         DN_CHK: begin
            if (key_s) begin
               state_nxt = UP;
               cnt_nxt   = '0;
            end else if (cnt == DB_LAST) begin
               state_nxt = DOWN;
               cnt_nxt   = '0;
               key_evt   = 1'b1;
            end else begin
               cnt_nxt = cnt + DEBOUNCE_W'(1);
            end
         end
         DOWN: begin
            if (key_s) begin
               state_nxt = UP_CHK;
               cnt_nxt   = '0;
            end
         end
         UP_CHK: begin
            if (!key_s) begin
               state_nxt = DOWN;
               cnt_nxt   = '0;
            end else if (cnt == DB_LAST) begin
               state_nxt = UP;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + DEBOUNCE_W'(1);
            end
         end
         default: begin
            state_nxt = UP;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Key and auto sources merge into one advance, only ever on a frame boundary.
   assign auto_hit = frame_start && auto_en && (auto_cnt == AUTO_LAST);
   assign adv      = frame_start && (req_pend || key_evt || auto_hit);

   // Mode register, change strobe, pending-key latch and auto frame counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_sel <= 2'd0;
         mode_chg <= 1'b0;
         req_pend <= 1'b0;
         auto_cnt <= '0;
      end else begin
         mode_chg <= adv;
         if (adv) begin
            mode_sel <= (mode_sel == MODE_LAST) ? 2'd0 : mode_sel + 2'd1;
         end
         if (adv) begin
            req_pend <= 1'b0;
         end else if (key_evt) begin
            req_pend <= 1'b1;
         end
         if (!auto_en || adv) begin
            auto_cnt <= '0;
         end else if (frame_start) begin
            auto_cnt <= auto_cnt + AUTO_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_lcd_pattern_sched.sv
// tb/tb_lcd_pattern_sched.sv - directed self-checking bench for lcd_pattern_sched
module tb_lcd_pattern_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       frame_start;
   logic       key_n;
   logic       auto_en;
   logic [1:0] mode_sel;
   logic       mode_chg;
   logic       req_pend;

   int n_cmp = 0;
   int n_err = 0;
   int fc    = 0;

   lcd_pattern_sched #(
      .NUM_MODES    (4),
      .DEBOUNCE_CYC (8),
      .DEBOUNCE_W   (20),
      .AUTO_FRAMES  (3),
      .AUTO_W       (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .key_n       (key_n),
      .auto_en     (auto_en),
      .mode_sel    (mode_sel),
      .mode_chg    (mode_chg),
      .req_pend    (req_pend)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; frame_start is high for the last cycle of every 100-cycle frame.
   task automatic step();
      @(posedge clk);
      #1;
      fc          = (fc == 99) ? 0 : fc + 1;
      frame_start = (fc == 99);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Runs through the next frame_start edge; outputs then show its result.
   task automatic next_frame();
      int g;
      g = 0;
      while (!frame_start && g < 200) begin
         step();
         g++;
      end
      chk("frame_start_timeout", {31'd0, (g < 200)}, 32'd1);
      step();
   endtask

   task automatic press();
      key_n = 1'b0;
      steps(20);
      key_n = 1'b1;
      steps(20);
   endtask

   initial begin
      rst_n       = 1'b0;
      key_n       = 1'b1;
      auto_en     = 1'b0;
      frame_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mode_sel", mode_sel, 0);
      chk("rst_mode_chg", mode_chg, 0);
      chk("rst_req_pend", req_pend, 0);
      rst_n = 1'b1;

      // Idle frames: nothing changes
      for (int f = 0; f < 5; f++) begin
         next_frame();
         chk("idle_mode_sel", mode_sel, 0);
         chk("idle_mode_chg", mode_chg, 0);
         chk("idle_req_pend", req_pend, 0);
      end

      // Clean press mid-frame: pending after 11 cycles, applied at frame_start
      steps(30);
      key_n = 1'b0;
      steps(10);
      chk("press_pend_early", req_pend, 0);
      step();
      chk("press_pend_set", req_pend, 1);
      steps(9);
      key_n = 1'b1;
      next_frame();
      chk("press_mode_sel", mode_sel, 1);
      chk("press_mode_chg", mode_chg, 1);
      chk("press_pend_clr", req_pend, 0);
      step();
      chk("press_chg_1cyc", mode_chg, 0);

      // Bouncing key never reaches the debounce threshold
      steps(10);
      for (int i = 0; i < 40; i++) begin
         if (i % 3 == 0) key_n = ~key_n;
         step();
      end
      key_n = 1'b1;
      steps(5);
      chk("bounce_pend", req_pend, 0);
      next_frame();
      chk("bounce_mode_sel", mode_sel, 1);
      chk("bounce_mode_chg", mode_chg, 0);

      // Bring mode to 3 with two presses
      press();
      next_frame();
      chk("to2_mode_sel", mode_sel, 2);
      press();
      next_frame();
      chk("to3_mode_sel", mode_sel, 3);

      // Auto cycling with wrap: 3 -> 0 on frame 3, 0 -> 1 on frame 6
      auto_en = 1'b1;
      for (int f = 1; f <= 6; f++) begin
         next_frame();
         chk("auto_mode_sel", mode_sel, (f < 3) ? 3 : (f < 6) ? 0 : 1);
         chk("auto_mode_chg", mode_chg, (f == 3 || f == 6) ? 1 : 0);
      end

      // Key press in the frame before auto_hit: single advance, timer restarts
      next_frame();
      next_frame();
      chk("coal_pre_mode", mode_sel, 1);
      press();
      chk("coal_pend", req_pend, 1);
      next_frame();
      chk("coal_mode_sel", mode_sel, 2);
      chk("coal_mode_chg", mode_chg, 1);
      chk("coal_pend_clr", req_pend, 0);
      step();
      chk("coal_chg_1cyc", mode_chg, 0);
      next_frame();
      chk("coal_hold1", mode_sel, 2);
      next_frame();
      chk("coal_hold2", mode_sel, 2);
      next_frame();
      chk("coal_auto_next", mode_sel, 3);

      // Reset in the middle of a second debounce with a request pending
      auto_en = 1'b0;
      key_n = 1'b0;
      steps(20);
      chk("rstmid_pend", req_pend, 1);
      key_n = 1'b1;
      steps(20);
      key_n = 1'b0;
      steps(8);
      rst_n = 1'b0;
      #1;
      chk("rstmid_mode_sel", mode_sel, 0);
      chk("rstmid_mode_chg", mode_chg, 0);
      chk("rstmid_req_pend", req_pend, 0);
      steps(3);
      rst_n = 1'b1;
      steps(10);
      chk("rstrel_pend_early", req_pend, 0);
      step();
      chk("rstrel_pend_set", req_pend, 1);
      next_frame();
      chk("rstrel_mode_sel", mode_sel, 1);
      chk("rstrel_pend_clr", req_pend, 0);
      key_n = 1'b1;
      steps(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
